exception_ctrl: RTL and testbench
=================================

Name: exception_ctrl

Overview:
- Sequences exception and interrupt entry and return for the single-cycle LEGv8 core.
- Takes the decoder's invalid-opcode flag and status code, plus the asynchronous external interrupt line.
- Saves the return PC and cause, redirects fetch to the exception vector, and runs the four-phase ExtIRQ/ExcAck handshake with the interrupt source.
- Sits beside the fetch PC mux; drives its redirect select and target.

Parameters:
- N, 64, PC/address width.
- EXC_VECTOR, 64'h0000_0000_0000_00D8, handler entry address.
- IRQ_CODE, 4'b0001, ESR value recorded for an external interrupt.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- Exc  in  1  decoder: current instruction is invalid/unsupported.
- EStatus  in  4  decoder cause code, valid when Exc=1.
- ERet  in  1  decoder: current instruction is ERET.
- ExtIRQ  in  1  external interrupt request, asynchronous, level.
- pc_in  in  N  PC of the instruction in execution this cycle.
- ExcAck  out  1  interrupt acknowledge to the source, four-phase.
- exc_taken  out  1  combinational; current instruction is squashed (no regWrite/memWrite commit).
- pc_redirect  out  1  combinational; next PC = pc_target instead of PC+4/branch.
- pc_target  out  N  combinational; EXC_VECTOR on entry, ERR on return.
- ERR  out  N  registered saved return PC.
- ESR  out  4  registered saved cause.
- in_handler  out  1  registered; 1 while state=HANDLER; external interrupts masked.
- halt  out  1  registered; 1 in FAULT state; core stops fetching.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; ERR=0; ESR=0; ExcAck=0; both sync flops=0; ack_pend=0; halt=0; in_handler=0.
  - Release is sampled at the first clk edge with reset=1.
- ExtIRQ synchronizer: 2-flop, irq_s = second flop. An assertion is visible 2 edges after ExtIRQ rises.
- States: IDLE, HANDLER, FAULT.
- IDLE, priority Exc > irq_s > ERet:
  - Exc=1: exc_taken=1, pc_redirect=1, pc_target=EXC_VECTOR. At the edge: ERR<=pc_in, ESR<=EStatus, state<=HANDLER.
  - Else irq_s=1 and ack_pend=0: same redirect and squash, ESR<=IRQ_CODE, ERR<=pc_in (interrupted instruction re-executes after ERET). ExcAck<=1, state<=HANDLER.
  - ERet=1 in IDLE: ignored; no redirect; the instruction is a no-op.
- HANDLER:
  - irq_s is ignored (masked).
  - Exc=1: double fault. exc_taken=1, pc_redirect=0, state<=FAULT, halt<=1. ERR and ESR are unchanged.
  - Else ERet=1: pc_redirect=1, pc_target=ERR, state<=IDLE. exc_taken=0 (ERET itself commits nothing).
  - Exc and ERet both 1: Exc wins, giving FAULT.
- FAULT: terminal until reset. halt=1, pc_redirect=0, all inputs ignored except the ExcAck handshake.
- ExcAck handshake, independent of state:
  - Set at IRQ acceptance; cleared the edge after irq_s is seen low.
  - ack_pend=ExcAck. A new IRQ cannot be accepted while ack_pend=1, even after ERET; this prevents double-taking one level request.
- A pending IRQ at the ERET cycle is taken no earlier than the cycle after return to IDLE. The instruction at ERR executes zero cycles only if irq_s is still high with ack_pend=0.
- ERR/ESR update only on entry edges; they hold value otherwise, including across ERET.
- pc_target is don't-care but driven to EXC_VECTOR when pc_redirect=0.
- Reset asserted mid-HANDLER or in FAULT returns to IDLE immediately, with all registers cleared.

Test Plan:
- Reset: reset=0 with random inputs → all outputs 0, state IDLE; release reset, no inputs → pc_redirect stays 0 for 10 cycles.
- Invalid opcode: IDLE, pc_in=0x40, Exc=1, EStatus=4'b0010 → same cycle pc_redirect=1, pc_target=0xD8, exc_taken=1; next edge ERR=0x40, ESR=2, in_handler=1; then ERet=1 → pc_target=0x40, IDLE next edge.
- Interrupt handshake: ExtIRQ rises at cycle 0, pc_in=0x100 → redirect at cycle 2, ESR=1, ERR=0x100, ExcAck=1. Hold ExtIRQ high through ERET → no re-entry. Drop ExtIRQ → ExcAck=0 three edges later.
- Simultaneous: irq_s=1 and Exc=1 in IDLE, EStatus=3 → ESR=3, ExcAck stays 0, IRQ taken after ERET at cycle ERET+1.
- Double fault: in HANDLER, Exc=1 with ERet=1 → exc_taken=1, pc_redirect=0, halt=1 next edge; ERR unchanged; further ERet ignored until reset.
- Reset mid-handler: HANDLER with ExcAck=1, pulse reset=0 between edges → ExcAck, in_handler, ERR drop to 0 without a clock edge.

Source files
------------

// File: rtl/exception_ctrl.sv
// Exception/interrupt entry and return sequencer for the single-cycle LEGv8 core.
// Squashes the faulting instruction, saves ERR/ESR, redirects fetch and runs the ExtIRQ/ExcAck handshake.
module exception_ctrl #(
    parameter int           N          = 64,
    parameter logic [N-1:0] EXC_VECTOR = 64'h0000_0000_0000_00D8,
    parameter logic [3:0]   IRQ_CODE   = 4'b0001
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         Exc,
    input  logic [3:0]   EStatus,
    input  logic         ERet,
    input  logic         ExtIRQ,
    input  logic [N-1:0] pc_in,
    output logic         ExcAck,
    output logic         exc_taken,
    output logic         pc_redirect,
    output logic [N-1:0] pc_target,
    output logic [N-1:0] ERR,
    output logic [3:0]   ESR,
    output logic         in_handler,
    output logic         halt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HANDLER = 2'd1,
        FAULT   = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic irq_p0;
    logic irq_p1;
    logic irq_s;
    logic ack_pend;
    logic exc_entry;
    logic irq_entry;
    logic load_ctx;

    assign irq_s    = irq_p1;
    assign ack_pend = ExcAck;

    // An interrupt is only accepted once the previous acknowledge has fully retired,
    // so a single level request can never be taken twice.
    assign exc_entry = (state_q == IDLE) && Exc;
    assign irq_entry = (state_q == IDLE) && !Exc && irq_s && !ack_pend;
    assign load_ctx  = exc_entry || irq_entry;

    // ---- ExtIRQ synchronizer ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_p0 <= 1'b0;
            irq_p1 <= 1'b0;
        end else begin
            irq_p0 <= ExtIRQ;
            irq_p1 <= irq_p0;
        end
    end

    // ---- state register ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            in_handler <= 1'b0;
            halt       <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_handler <= (state_d == HANDLER);
            halt       <= (state_d == FAULT);
        end
    end

    // ---- next-state logic ----
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (load_ctx) begin
                    state_d = HANDLER;
                end
            end
            HANDLER: begin
                if (Exc) begin
                    state_d = FAULT;
                end else if (ERet) begin
                    state_d = IDLE;
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ---- output logic ----
    // Redirect/squash are held low while reset is asserted so the core never
    // sees a spurious redirect from inputs that happen to be active during reset.
    always_comb begin
        exc_taken   = 1'b0;
        pc_redirect = 1'b0;
        pc_target   = EXC_VECTOR;
        if (reset) begin
            unique case (state_q)
                IDLE: begin
                    if (load_ctx) begin
                        exc_taken   = 1'b1;
                        pc_redirect = 1'b1;
                    end
                end
                HANDLER: begin
                    if (Exc) begin
                        exc_taken = 1'b1;
                    end else if (ERet) begin
                        pc_redirect = 1'b1;
                        pc_target   = ERR;
                    end
                end
                default: begin
                    exc_taken   = 1'b0;
                    pc_redirect = 1'b0;
                end
            endcase
        end
    end

    // ---- saved context and acknowledge ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ERR    <= '0;
            ESR    <= '0;
            ExcAck <= 1'b0;
        end else begin
            if (load_ctx) begin
                ERR <= pc_in;
                ESR <= irq_entry ? IRQ_CODE : EStatus;
            end
            if (irq_entry) begin
                ExcAck <= 1'b1;
            end else if (ExcAck && !irq_s) begin
                ExcAck <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_exception_ctrl.sv
// Directed bench for exception_ctrl: literal checks per scenario plus a per-cycle
// comparison against a behavioural model of the entry/return/handshake rules.
module tb_exception_ctrl;

    localparam logic [63:0] VEC = 64'h0000_0000_0000_00D8;

    logic        clk;
    logic        reset;
    logic        Exc;
    logic [3:0]  EStatus;
    logic        ERet;
    logic        ExtIRQ;
    logic [63:0] pc_in;
    logic        ExcAck;
    logic        exc_taken;
    logic        pc_redirect;
    logic [63:0] pc_target;
    logic [63:0] ERR;
    logic [3:0]  ESR;
    logic        in_handler;
    logic        halt;

    int vectors = 0;
    int miscompares = 0;

    exception_ctrl #(
        .N(64),
        .EXC_VECTOR(VEC),
        .IRQ_CODE(4'b0001)
    ) dut (
        .clk(clk),
        .reset(reset),
        .Exc(Exc),
        .EStatus(EStatus),
        .ERet(ERet),
        .ExtIRQ(ExtIRQ),
        .pc_in(pc_in),
        .ExcAck(ExcAck),
        .exc_taken(exc_taken),
        .pc_redirect(pc_redirect),
        .pc_target(pc_target),
        .ERR(ERR),
        .ESR(ESR),
        .in_handler(in_handler),
        .halt(halt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0 = normal, 1 = in handler, 2 = halted.
    // The interrupt line becomes visible two clock edges after it is sampled.
    int          m_mode = 0;
    logic [63:0] m_err  = '0;
    logic [3:0]  m_esr  = '0;
    logic        m_ack  = 1'b0;
    logic [1:0]  m_hist = 2'b00;

    wire m_vis    = m_hist[1];
    wire m_accept = (m_mode == 0) && !Exc && m_vis && !m_ack;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_mode <= 0;
            m_err  <= '0;
            m_esr  <= '0;
            m_ack  <= 1'b0;
            m_hist <= 2'b00;
        end else begin
            m_hist <= {m_hist[0], ExtIRQ};
            if (m_mode == 0 && Exc) begin
                m_err  <= pc_in;
                m_esr  <= EStatus;
                m_mode <= 1;
            end else if (m_accept) begin
                m_err  <= pc_in;
                m_esr  <= 4'd1;
                m_mode <= 1;
            end else if (m_mode == 1 && Exc) begin
                m_mode <= 2;
            end else if (m_mode == 1 && ERet) begin
                m_mode <= 0;
            end
            m_ack <= m_accept ? 1'b1 : ((m_ack && !m_vis) ? 1'b0 : m_ack);
        end
    end

    wire        exp_taken  = reset && (((m_mode == 0) && (Exc || (m_vis && !m_ack))) || ((m_mode == 1) && Exc));
    wire        exp_redir  = reset && (((m_mode == 0) && (Exc || (m_vis && !m_ack))) || ((m_mode == 1) && !Exc && ERet));
    wire [63:0] exp_target = (exp_redir && m_mode == 1) ? m_err : VEC;

    always @(negedge clk) begin
        chk("model_exc_taken", 64'(exc_taken), 64'(exp_taken));
        chk("model_pc_redirect", 64'(pc_redirect), 64'(exp_redir));
        chk("model_pc_target", pc_target, exp_target);
        chk("model_ERR", ERR, m_err);
        chk("model_ESR", 64'(ESR), 64'(m_esr));
        chk("model_ExcAck", 64'(ExcAck), 64'(m_ack));
        chk("model_in_handler", 64'(in_handler), 64'(m_mode == 1));
        chk("model_halt", 64'(halt), 64'(m_mode == 2));
    end

    // Apply one cycle of inputs just after the rising edge; returns once combinational outputs settle.
    task automatic drive(input logic e, input logic [3:0] es, input logic er, input logic irq,
                         input logic [63:0] pc);
        @(posedge clk);
        #1;
        Exc = e;
        EStatus = es;
        ERet = er;
        ExtIRQ = irq;
        pc_in = pc;
        #1;
    endtask

    initial begin
        reset = 1'b0;
        Exc = 1'b0;
        EStatus = 4'd0;
        ERet = 1'b0;
        ExtIRQ = 1'b0;
        pc_in = '0;

        // Reset held with random inputs
        repeat (3) begin
            @(posedge clk);
            #1;
            Exc = 1'($urandom_range(1));
            ERet = 1'($urandom_range(1));
            ExtIRQ = 1'($urandom_range(1));
            EStatus = 4'($urandom_range(15));
            pc_in = {$urandom, $urandom};
            #1;
            chk("rst_exc_taken", 64'(exc_taken), 64'd0);
            chk("rst_pc_redirect", 64'(pc_redirect), 64'd0);
            chk("rst_ExcAck", 64'(ExcAck), 64'd0);
            chk("rst_ERR", ERR, 64'd0);
            chk("rst_ESR", 64'(ESR), 64'd0);
            chk("rst_in_handler", 64'(in_handler), 64'd0);
            chk("rst_halt", 64'(halt), 64'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        Exc = 1'b0;
        ERet = 1'b0;
        ExtIRQ = 1'b0;
        EStatus = 4'd0;
        pc_in = '0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 4'd0, 1'b0, 1'b0, 64'(4 * i));
            chk("idle_no_redirect", 64'(pc_redirect), 64'd0);
        end

        // Invalid opcode entry and ERET
        drive(1'b1, 4'd2, 1'b0, 1'b0, 64'h40);
        chk("exc_taken", 64'(exc_taken), 64'd1);
        chk("exc_redirect", 64'(pc_redirect), 64'd1);
        chk("exc_target", pc_target, 64'hD8);
        drive(1'b0, 4'd0, 1'b0, 1'b0, 64'hD8);
        chk("exc_ERR", ERR, 64'h40);
        chk("exc_ESR", 64'(ESR), 64'd2);
        chk("exc_in_handler", 64'(in_handler), 64'd1);
        chk("handler_no_redirect", 64'(pc_redirect), 64'd0);
        drive(1'b0, 4'd0, 1'b1, 1'b0, 64'hDC);
        chk("eret_redirect", 64'(pc_redirect), 64'd1);
        chk("eret_target", pc_target, 64'h40);
        chk("eret_no_squash", 64'(exc_taken), 64'd0);
        drive(1'b0, 4'd0, 1'b0, 1'b0, 64'h40);
        chk("eret_idle", 64'(in_handler), 64'd0);
        drive(1'b0, 4'd0, 1'b1, 1'b0, 64'h44);
        chk("idle_eret_ignored", 64'(pc_redirect), 64'd0);
        chk("idle_ERR_held", ERR, 64'h40);

        // External interrupt with four-phase acknowledge
        drive(1'b0, 4'd0, 1'b0, 1'b1, 64'h100);
        chk("irq_cycle0", 64'(pc_redirect), 64'd0);
        drive(1'b0, 4'd0, 1'b0, 1'b1, 64'h100);
        chk("irq_cycle1", 64'(pc_redirect), 64'd0);
        drive(1'b0, 4'd0, 1'b0, 1'b1, 64'h100);
        chk("irq_cycle2_redirect", 64'(pc_redirect), 64'd1);
        chk("irq_cycle2_taken", 64'(exc_taken), 64'd1);
        chk("irq_cycle2_target", pc_target, 64'hD8);
        drive(1'b0, 4'd0, 1'b0, 1'b1, 64'hD8);
        chk("irq_ESR", 64'(ESR), 64'd1);
        chk("irq_ERR", ERR, 64'h100);
        chk("irq_ExcAck", 64'(ExcAck), 64'd1);
        chk("irq_in_handler", 64'(in_handler), 64'd1);
        drive(1'b0, 4'd0, 1'b0, 1'b1, 64'hDC);
        chk("irq_masked", 64'(pc_redirect), 64'd0);
        drive(1'b0, 4'd0, 1'b1, 1'b1, 64'hE0);
        chk("irq_eret_target", pc_target, 64'h100);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 4'd0, 1'b0, 1'b1, 64'(64'h100 + 4 * i));
            chk("irq_no_reentry", 64'(pc_redirect), 64'd0);
            chk("irq_ack_held", 64'(ExcAck), 64'd1);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 4'd0, 1'b0, 1'b0, 64'(64'h10C + 4 * i));
            chk("ack_before_drop", 64'(ExcAck), 64'd1);
        end
        drive(1'b0, 4'd0, 1'b0, 1'b0, 64'h118);
        chk("ack_dropped", 64'(ExcAck), 64'd0);

        // Simultaneous exception and interrupt
        drive(1'b0, 4'd0, 1'b0, 1'b1, 64'h1F8);
        drive(1'b0, 4'd0, 1'b0, 1'b1, 64'h1FC);
        drive(1'b1, 4'd3, 1'b0, 1'b1, 64'h200);
        chk("sim_taken", 64'(exc_taken), 64'd1);
        chk("sim_target", pc_target, 64'hD8);
        drive(1'b0, 4'd0, 1'b0, 1'b1, 64'hD8);
        chk("sim_ESR", 64'(ESR), 64'd3);
        chk("sim_ERR", ERR, 64'h200);
        chk("sim_no_ack", 64'(ExcAck), 64'd0);
        drive(1'b0, 4'd0, 1'b1, 1'b1, 64'hDC);
        chk("sim_eret_target", pc_target, 64'h200);
        drive(1'b0, 4'd0, 1'b0, 1'b1, 64'h200);
        chk("sim_irq_after_eret", 64'(pc_redirect), 64'd1);
        chk("sim_irq_squash", 64'(exc_taken), 64'd1);
        drive(1'b0, 4'd0, 1'b0, 1'b1, 64'hD8);
        chk("sim_irq_ESR", 64'(ESR), 64'd1);
        chk("sim_irq_ERR", ERR, 64'h200);
        chk("sim_irq_ack", 64'(ExcAck), 64'd1);
        drive(1'b0, 4'd0, 1'b1, 1'b1, 64'hDC);
        chk("sim_irq_eret", pc_target, 64'h200);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 4'd0, 1'b0, 1'b0, 64'(64'h200 + 4 * i));
            chk("sim_quiet", 64'(pc_redirect), 64'd0);
        end
        chk("sim_ack_cleared", 64'(ExcAck), 64'd0);

        // Double fault
        drive(1'b1, 4'd5, 1'b0, 1'b0, 64'h500);
        chk("df_entry", 64'(exc_taken), 64'd1);
        drive(1'b0, 4'd0, 1'b0, 1'b0, 64'hD8);
        chk("df_in_handler", 64'(in_handler), 64'd1);
        drive(1'b1, 4'd7, 1'b1, 1'b0, 64'hDC);
        chk("df_taken", 64'(exc_taken), 64'd1);
        chk("df_no_redirect", 64'(pc_redirect), 64'd0);
        drive(1'b0, 4'd0, 1'b1, 1'b1, 64'hE0);
        chk("df_halt", 64'(halt), 64'd1);
        chk("df_not_handler", 64'(in_handler), 64'd0);
        chk("df_ERR", ERR, 64'h500);
        chk("df_ESR", 64'(ESR), 64'd5);
        chk("df_eret_ignored", 64'(pc_redirect), 64'd0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'd0, 1'b1, 1'b1, 64'(64'hE4 + 4 * i));
            chk("fault_no_redirect", 64'(pc_redirect), 64'd0);
            chk("fault_no_squash", 64'(exc_taken), 64'd0);
            chk("fault_halt", 64'(halt), 64'd1);
        end

        // Reset out of FAULT, then asynchronous reset mid-handler
        @(posedge clk);
        #1;
        reset = 1'b0;
        Exc = 1'b0;
        ERet = 1'b0;
        ExtIRQ = 1'b0;
        #1;
        chk("fault_reset_halt", 64'(halt), 64'd0);
        reset = 1'b1;
        drive(1'b0, 4'd0, 1'b0, 1'b1, 64'h700);
        drive(1'b0, 4'd0, 1'b0, 1'b1, 64'h700);
        drive(1'b0, 4'd0, 1'b0, 1'b1, 64'h700);
        chk("mid_entry", 64'(pc_redirect), 64'd1);
        drive(1'b0, 4'd0, 1'b0, 1'b1, 64'hD8);
        chk("mid_ack", 64'(ExcAck), 64'd1);
        chk("mid_ERR", ERR, 64'h700);
        #1;
        reset = 1'b0;
        #1;
        chk("async_ExcAck", 64'(ExcAck), 64'd0);
        chk("async_in_handler", 64'(in_handler), 64'd0);
        chk("async_ERR", ERR, 64'd0);
        chk("async_ESR", 64'(ESR), 64'd0);
        reset = 1'b1;
        ExtIRQ = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 4'd0, 1'b0, 1'b0, 64'(4 * i));
            chk("post_reset_idle", 64'(pc_redirect), 64'd0);
        end

        @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
